// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the execute-stage integer divider.
// Operand extension helper is used by the controller's operand prep.
package div_ctrl_pkg;

    typedef logic [63:0]  u64;
    typedef logic [127:0] u128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITER_X = 64;
    localparam int DIV_ITER_W = 32;
    localparam int DIV_TAG_W  = 5;

    typedef struct packed {
        logic                 is_signed;
        logic                 is32;
        u64                   a;
        u64                   b;
        logic [DIV_TAG_W-1:0] tag;
    } div_req_t;

    // W-form operands only carry bits [31:0]; widen them to 64 bits.
    function automatic u64 div_extend(input u64 x, input logic is_signed, input logic is32);
        if (!is32) begin
            return x;
        end
        return is_signed ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
    endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, quotient bits
// shift into the dividend register as the dividend bits shift out.
module div_core
    import div_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] iters,
    input  u64         dividend,
    input  u64         divisor,
    input  logic       abort,
    output logic       done,
    output u64         quotient
);

    u64         rem_reg;
    u64         dvd_reg;
    u64         div_reg;
    logic [5:0] cnt_reg;
    logic       run_reg;

    logic [64:0] rem_sh;
    logic [64:0] diff;
    logic        take;

    // A borrow out of the 65-bit subtract means the shifted remainder is
    // still smaller than the divisor.
    always_comb begin
        rem_sh = {rem_reg, dvd_reg[63]};
        diff   = rem_sh - {1'b0, div_reg};
        take   = ~diff[64];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg <= '0;
            dvd_reg <= '0;
            div_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (abort) begin
            run_reg <= 1'b0;
        end else if (start) begin
            rem_reg <= '0;
            dvd_reg <= dividend;
            div_reg <= divisor;
            cnt_reg <= 6'(iters - 7'd1);
            run_reg <= 1'b1;
        end else if (run_reg) begin
            rem_reg <= take ? diff[63:0] : rem_sh[63:0];
            dvd_reg <= {dvd_reg[62:0], take};
            cnt_reg <= cnt_reg - 6'd1;
            if (cnt_reg == 6'd0) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign done     = run_reg & (cnt_reg == 6'd0);
    assign quotient = dvd_reg;

endmodule

// File: rtl/div_ctrl.sv
// UDIV/SDIV sequencing controller: operand prep, divide-by-zero bypass,
// sign/width fix-up of the core's quotient and the response handshake.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic             req_is32,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_q,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    div_state_t       state_reg, state_next;
    logic [TAG_W-1:0] tag_reg;
    logic             is32_reg;
    logic             neg_reg;
    logic             zero_reg;

    u64         a_ext, b_ext, a_mag, b_mag, core_dvd, core_q, q_fix;
    logic       a_neg, b_neg, b_zero;
    logic       accept, start, core_done;
    logic [6:0] iters;

    always_comb begin
        a_ext    = div_extend(req_a, req_signed, req_is32);
        b_ext    = div_extend(req_b, req_signed, req_is32);
        a_neg    = req_signed & a_ext[63];
        b_neg    = req_signed & b_ext[63];
        a_mag    = a_neg ? (64'd0 - a_ext) : a_ext;
        b_mag    = b_neg ? (64'd0 - b_ext) : b_ext;
        b_zero   = (b_mag == 64'd0);
        // W dividends sit in the top half so 32 iterations leave the quotient in the low half.
        core_dvd = req_is32 ? {a_mag[31:0], 32'b0} : a_mag;
        iters    = req_is32 ? 7'(DIV_ITER_W) : 7'(DIV_ITER_X);
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg == RUN) || (state_reg == DONE);
    assign accept    = req_valid & req_ready & ~flush;
    assign start     = accept & ~b_zero;

    div_core u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .iters    (iters),
        .dividend (core_dvd),
        .divisor  (b_mag),
        .abort    (flush),
        .done     (core_done),
        .quotient (core_q)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = b_zero ? DONE : RUN;
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (core_done) begin
                    state_next = DONE;
                end
            end
            DONE: if (flush || resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            tag_reg   <= '0;
            is32_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                tag_reg  <= req_tag;
                is32_reg <= req_is32;
                neg_reg  <= ~b_zero & (a_neg ^ b_neg);
                zero_reg <= b_zero;
            end
        end
    end

    // INT_MIN / -1 falls out of the 64-bit negate with no special case.
    always_comb begin
        q_fix      = neg_reg ? (64'd0 - core_q) : core_q;
        resp_valid = (state_reg == DONE);
        resp_q     = '0;
        resp_tag   = '0;
        if (state_reg == DONE) begin
            resp_tag = tag_reg;
            if (!zero_reg) begin
                resp_q = is32_reg ? {32'b0, q_fix[31:0]} : q_fix;
            end
        end
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the execute-stage integer divider. Accepts AArch64 UDIV/SDIV requests in X (64-bit) or W (32-bit) form, normalises operands, and drives an internal unsigned restoring-division core one quotient bit per cycle. It applies the sign and width corrections, short-circuits divide-by-zero, and returns the quotient through a valid/ready response. It holds off the pipeline through `busy` and aborts cleanly on `flush`.

## Interface
Parameters:
- TAG_W, 5, width of the pass-through destination tag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_signed  in  1  1 = SDIV, 0 = UDIV
- req_is32  in  1  1 = W form (low 32 bits only), 0 = X form
- req_a  in  64  dividend
- req_b  in  64  divisor
- req_tag  in  TAG_W  opaque tag, returned with the result
- flush  in  1  abort any in-flight or pending operation
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_q  out  64  quotient (W results zero-extended)
- resp_tag  out  TAG_W  tag of the completed request
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Encoding is `div_state_t`.
- Accept: `req_valid & req_ready & ~flush` in IDLE.
  - Capture `req_tag`, `req_signed`, `req_is32`.
  - Operand prep:
    - W form: use bits [31:0]; sign-extend if signed, otherwise zero-extend.
    - If signed: take magnitudes |a|, |b| as 64-bit unsigned values, and set neg = sign(a) ^ sign(b).
- Divisor zero after prep → DONE with quotient 0 and neg = 0. The core is not started.
- Otherwise → RUN for N cycles (N = 64 for X, 32 for W).
  - For W, the dividend is pre-shifted left by 32 so 32 iterations produce the quotient.
  - Each cycle: {rem, dvd} <<= 1. If rem ≥ divisor, subtract the divisor and set the quotient LSB.
  - An iteration counter runs N-1 down to 0. Its terminal count moves the state to DONE.
- DONE: `resp_valid` = 1.
  - resp_q = neg ? -q : q, computed in 64 bits.
  - For W, the result is truncated to [31:0] and zero-extended.
  - `resp_valid & resp_ready` → IDLE.
- Overflow needs no special path. SDIV INT_MIN / -1 yields INT_MIN for both widths (X: 0x8000000000000000, W: 0x0000000080000000).
- Truncation is toward zero. There is no remainder output, because MSUB recomputes it.
- flush:
  - Any state → IDLE on the next edge.
  - No response is produced, and an unacknowledged DONE result is dropped.
  - flush wins over an accept in the same cycle.
- flush and `resp_ready` in the same DONE cycle: treat as flush. The result is not delivered.
- reset has priority over everything.
  - State → IDLE, counter 0, datapath registers 0.
  - Outputs: req_ready = 1, resp_valid = 0, resp_q = 0, resp_tag = 0, busy = 0.

## Timing
- Accept at cycle T → resp_valid first high at T+N+1 (X: T+65, W: T+33).
- Divide-by-zero: resp_valid at T+1.
- While resp_valid is high and resp_ready is low, resp_q and resp_tag hold stable for any number of cycles.
- req_ready is combinational from state only; it has no path from req_valid.
- No accept occurs in the same cycle as a response handshake. The next accept is possible one cycle after the DONE→IDLE edge.
- busy is combinational from state. The stall logic uses it to hold younger instructions.

## Structure
- Package `common` (shared):
  - `div_state_t` enum {IDLE, RUN, DONE}
  - constants DIV_ITER_X = 64, DIV_ITER_W = 32
  - packed struct `div_req_t` {signed, is32, a, b, tag}
  - reuse the existing u64/u128 typedefs.
- Sub-module `div_core`: the unsigned restoring iteration datapath.
  - Inputs: start, iters, dividend, divisor, abort.
  - Outputs: done, quotient.
  - div_ctrl owns the FSM, operand prep, sign fix-up and handshake.

## Test plan
- UDIV X: a=100, b=7 → resp_q=14, resp_valid at T+65. Hold resp_ready=0 for 5 cycles → resp_q/resp_tag stable, then IDLE the cycle after the handshake.
- SDIV X: a=-100, b=7 → 0xFFFFFFFFFFFFFFF2. a=-7, b=2 → 0xFFFFFFFFFFFFFFFD (truncation toward zero). a=0x8000000000000000, b=-1 → 0x8000000000000000.
- W form:
  - UDIV a=0xDEADBEEF00000010, b=0x1234567800000002 → 8 at T+33.
  - SDIV a=0x80000000, b=0xFFFFFFFF → 0x0000000080000000.
  - SDIV a=0xFFFFFFF6, b=3 → 0x00000000FFFFFFFD.
- Divide-by-zero, X and W, signed and unsigned: a=12345, b=0 → resp_q=0 at T+1, tag preserved.
- flush at T+10 of an X divide → no resp_valid, req_ready=1 at T+11. A following 81/9 request returns 9. flush asserted together with req_valid in IDLE → request not accepted.
- reset asserted mid-RUN → next cycle req_ready=1, resp_valid=0, busy=0. A new 1000/10 request returns 100.
